// File: rtl/pc_sequencer_if.sv
// Redirect / fetch-address bundle between ID-stage control and the PC sequencer.
// master: drives the redirect requests and samples the fetch state (ID stage, testbench).
// slave:  the pc_sequencer itself.
interface pc_sequencer_if;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchPCPlus4;
  logic [31:0] BranchOffset;
  logic        Jump;
  logic [25:0] JumpAddr26;
  logic        JumpRegister;
  logic [31:0] JRTarget;
  logic        ClearError;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        IFIDFlush;
  logic        AddrError;
  logic [31:0] BadVAddr;
  logic [15:0] RedirectCount;

  modport master (
    output Stall, BranchTaken, BranchPCPlus4, BranchOffset, Jump, JumpAddr26,
           JumpRegister, JRTarget, ClearError,
    input  PC, PCPlus4, IFIDFlush, AddrError, BadVAddr, RedirectCount
  );

  modport slave (
    input  Stall, BranchTaken, BranchPCPlus4, BranchOffset, Jump, JumpAddr26,
           JumpRegister, JRTarget, ClearError,
    output PC, PCPlus4, IFIDFlush, AddrError, BadVAddr, RedirectCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next fetch address from sequential,
// branch, jump and jump-register sources, traps misaligned JR targets to an
// exception vector and counts accepted redirects.
// Optional build macro: PC_SEQUENCER_DELAY_SLOT_EN -- aligned redirects keep the
// delay-slot instruction (no IF/ID flush); only trapping JRs flush.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic               clk,
  input  logic               reset,
  pc_sequencer_if.slave      bus
);

  typedef enum logic [0:0] {StRun, StTrap} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] bad_vaddr_q, bad_vaddr_d;
  logic [15:0] redirect_count_q, redirect_count_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        accepted;
  logic        jr_misaligned;

  // Redirect target arithmetic and acceptance decode.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    branch_target = bus.BranchPCPlus4 + {bus.BranchOffset[29:0], 2'b00};
    jump_target   = {bus.BranchPCPlus4[31:28], bus.JumpAddr26, 2'b00};
    accepted      = !bus.Stall && (bus.JumpRegister || bus.Jump || bus.BranchTaken);
    // JR has top priority, so a misaligned JR target always wins the cycle.
    jr_misaligned = !bus.Stall && bus.JumpRegister && (bus.JRTarget[1:0] != 2'b00);
  end

  // Next-state: PC select, trap FSM, fault address capture, saturating counter.
  always_comb begin
    pc_d             = pc_q;
    state_d          = state_q;
    bad_vaddr_d      = bad_vaddr_q;
    redirect_count_d = redirect_count_q;

    if (!bus.Stall) begin
      if (jr_misaligned) begin
        pc_d        = EXC_VECTOR;
        bad_vaddr_d = bus.JRTarget;
      end else if (bus.JumpRegister) begin
        pc_d = bus.JRTarget;
      end else if (bus.Jump) begin
        pc_d = jump_target;
      end else if (bus.BranchTaken) begin
        pc_d = branch_target;
      end else begin
        pc_d = pc_plus4;
      end
    end

    unique case (state_q)
      StRun: begin
        if (jr_misaligned) state_d = StTrap;
      end
      StTrap: begin
        // A misaligned JR in the same cycle overrides the acknowledge.
        if (bus.ClearError && !jr_misaligned) state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    if (accepted && (redirect_count_q != 16'hFFFF)) begin
      redirect_count_d = redirect_count_q + 16'd1;
    end
  end

  // State registers; reset abandons any redirect presented in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q             <= RESET_PC;
      state_q          <= StRun;
      bad_vaddr_q      <= 32'h0;
      redirect_count_q <= 16'h0;
    end else begin
      pc_q             <= pc_d;
      state_q          <= state_d;
      bad_vaddr_q      <= bad_vaddr_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  // Outputs; flush is derived only from accepted redirects, so it is low under Stall.
  always_comb begin
    bus.PC            = pc_q;
    bus.PCPlus4       = pc_plus4;
    bus.AddrError     = (state_q == StTrap);
    bus.BadVAddr      = bad_vaddr_q;
    bus.RedirectCount = redirect_count_q;
`ifdef PC_SEQUENCER_DELAY_SLOT_EN
    bus.IFIDFlush     = jr_misaligned;
`else
    bus.IFIDFlush     = accepted;
`endif
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vectors plus randomized
// redirects checked against a behavioural model of the fetch-address rules.
module tb_pc_sequencer;

  localparam logic [31:0] ResetPc = 32'h0040_0000;
  localparam logic [31:0] ExcVec  = 32'h8000_0180;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC  (ResetPc),
    .EXC_VECTOR(ExcVec)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

`ifdef PC_SEQUENCER_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  // Behavioural model state.
  logic [31:0] m_pc;
  bit          m_trap;
  logic [31:0] m_bad;
  int          m_cnt;

  // Next fetch state predicted from the current inputs and model state.
  function automatic void predict(output logic [31:0] npc, output bit ntrap,
                                  output logic [31:0] nbad, output int ncnt,
                                  output bit flush);
    bit took_redirect;
    bit traps;
    npc           = m_pc + 32'd4;
    ntrap         = m_trap;
    nbad          = m_bad;
    ncnt          = m_cnt;
    took_redirect = 1'b0;
    traps         = 1'b0;
    if (bus.Stall) begin
      npc = m_pc;
    end else if (bus.JumpRegister) begin
      took_redirect = 1'b1;
      if (bus.JRTarget % 4 != 0) begin
        traps = 1'b1;
        npc   = ExcVec;
        nbad  = bus.JRTarget;
        ntrap = 1'b1;
      end else begin
        npc = bus.JRTarget;
      end
    end else if (bus.Jump) begin
      took_redirect = 1'b1;
      npc = (bus.BranchPCPlus4 & 32'hF000_0000) + ({6'b0, bus.JumpAddr26} * 4);
    end else if (bus.BranchTaken) begin
      took_redirect = 1'b1;
      npc = bus.BranchPCPlus4 + bus.BranchOffset * 4;
    end
    if (!traps && m_trap && bus.ClearError) ntrap = 1'b0;
    if (took_redirect) ncnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    flush = traps || (took_redirect && !DelaySlot);
  endfunction

  function automatic bit exp_flush();
    logic [31:0] a, c;
    bit b, f;
    int d;
    predict(a, b, c, d, f);
    return f;
  endfunction

  task automatic model_reset();
    m_pc = ResetPc; m_trap = 1'b0; m_bad = 32'h0; m_cnt = 0;
  endtask

  task automatic set_idle();
    bus.Stall = 0; bus.BranchTaken = 0; bus.BranchPCPlus4 = 32'h0; bus.BranchOffset = 32'h0;
    bus.Jump = 0; bus.JumpAddr26 = 26'h0; bus.JumpRegister = 0; bus.JRTarget = 32'h0;
    bus.ClearError = 0;
  endtask

  // Advance one clock edge, updating the model with the same inputs.
  task automatic tick();
    logic [31:0] npc, nbad;
    bit ntrap, f;
    int ncnt;
    predict(npc, ntrap, nbad, ncnt, f);
    @(posedge clk);
    #1;
    m_pc = npc; m_trap = ntrap; m_bad = nbad; m_cnt = ncnt;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.PC !== ResetPc) begin
      n_fail++; $display("FAIL reset_pc: got %h want %h", bus.PC, ResetPc);
    end
    n_checks++;
    if (bus.RedirectCount !== 16'h0 || bus.AddrError !== 1'b0 || bus.BadVAddr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got cnt=%h err=%b bad=%h want 0/0/0",
               bus.RedirectCount, bus.AddrError, bus.BadVAddr);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] want;
    for (int i = 1; i <= 3; i++) begin
      n_checks++;
      if (bus.IFIDFlush !== 1'b0) begin
        n_fail++; $display("FAIL seq_flush[%0d]: got %b want 0", i, bus.IFIDFlush);
      end
      tick();
      want = ResetPc + 32'(4 * i);
      n_checks++;
      if (bus.PC !== want) begin
        n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.PC, want);
      end
    end
  endtask

  task automatic test_branch();
    set_idle();
    bus.BranchTaken = 1; bus.BranchPCPlus4 = 32'h0040_0010; bus.BranchOffset = 32'hFFFF_FFFC;
    #1;
    n_checks++;
    if (bus.IFIDFlush !== !DelaySlot) begin
      n_fail++; $display("FAIL branch_flush: got %b want %b", bus.IFIDFlush, !DelaySlot);
    end
    tick();
    n_checks++;
    if (bus.PC !== 32'h0040_0000 || bus.RedirectCount !== 16'd1) begin
      n_fail++;
      $display("FAIL branch_pc: got pc=%h cnt=%0d want 00400000/1", bus.PC, bus.RedirectCount);
    end
  endtask

  task automatic test_priority();
    set_idle();
    bus.Jump = 1; bus.BranchTaken = 1; bus.JumpRegister = 1; bus.JRTarget = 32'h0040_0100;
    bus.JumpAddr26 = 26'h155_5555; bus.BranchOffset = 32'h10; bus.BranchPCPlus4 = 32'h0040_0200;
    tick();
    n_checks++;
    if (bus.PC !== 32'h0040_0100 || bus.RedirectCount !== 16'd2) begin
      n_fail++;
      $display("FAIL prio_jr: got pc=%h cnt=%0d want 00400100/2", bus.PC, bus.RedirectCount);
    end
    bus.Stall = 1;
    #1;
    n_checks++;
    if (bus.IFIDFlush !== 1'b0) begin
      n_fail++; $display("FAIL stall_flush: got %b want 0", bus.IFIDFlush);
    end
    tick();
    n_checks++;
    if (bus.PC !== 32'h0040_0100 || bus.RedirectCount !== 16'd2) begin
      n_fail++;
      $display("FAIL stall_hold: got pc=%h cnt=%0d want 00400100/2", bus.PC, bus.RedirectCount);
    end
    // Jump beats branch when JR is absent.
    bus.Stall = 0; bus.JumpRegister = 0;
    tick();
    n_checks++;
    if (bus.PC !== 32'h0555_5554) begin
      n_fail++; $display("FAIL prio_j: got %h want 05555554", bus.PC);
    end
  endtask

  task automatic test_misaligned();
    set_idle();
    bus.JumpRegister = 1; bus.JRTarget = 32'h0040_0102;
    #1;
    n_checks++;
    if (bus.IFIDFlush !== 1'b1) begin
      n_fail++; $display("FAIL trap_flush: got %b want 1", bus.IFIDFlush);
    end
    tick();
    n_checks++;
    if (bus.PC !== ExcVec || bus.AddrError !== 1'b1 || bus.BadVAddr !== 32'h0040_0102) begin
      n_fail++;
      $display("FAIL trap_enter: got pc=%h err=%b bad=%h want 80000180/1/00400102",
               bus.PC, bus.AddrError, bus.BadVAddr);
    end
    // Misaligned JR and acknowledge together: the trap persists and reloads.
    bus.JRTarget = 32'h0000_0003; bus.ClearError = 1;
    tick();
    n_checks++;
    if (bus.PC !== ExcVec || bus.AddrError !== 1'b1 || bus.BadVAddr !== 32'h0000_0003) begin
      n_fail++;
      $display("FAIL trap_nest: got pc=%h err=%b bad=%h want 80000180/1/00000003",
               bus.PC, bus.AddrError, bus.BadVAddr);
    end
    set_idle();
    bus.ClearError = 1;
    tick();
    n_checks++;
    if (bus.AddrError !== 1'b0 || bus.PC !== ExcVec + 32'd4 || bus.BadVAddr !== 32'h3) begin
      n_fail++;
      $display("FAIL trap_clear: got err=%b pc=%h bad=%h want 0/80000184/00000003",
               bus.AddrError, bus.PC, bus.BadVAddr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.Stall         = ($urandom_range(0, 3) == 0);
      bus.BranchTaken   = $urandom_range(0, 1);
      bus.BranchPCPlus4 = $urandom;
      bus.BranchOffset  = $urandom;
      bus.Jump          = ($urandom_range(0, 2) == 0);
      bus.JumpAddr26    = 26'($urandom);
      bus.JumpRegister  = ($urandom_range(0, 3) == 0);
      bus.JRTarget      = $urandom;
      bus.ClearError    = $urandom_range(0, 1);
      #1;
      n_checks++;
      if (bus.IFIDFlush !== exp_flush() || bus.PCPlus4 !== m_pc + 32'd4) begin
        n_fail++;
        $display("FAIL rand_comb[%0d]: got flush=%b pc4=%h want %b/%h",
                 i, bus.IFIDFlush, bus.PCPlus4, exp_flush(), m_pc + 32'd4);
      end
      tick();
      n_checks++;
      if (bus.PC !== m_pc || bus.AddrError !== m_trap || bus.BadVAddr !== m_bad ||
          bus.RedirectCount !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got pc=%h err=%b bad=%h cnt=%0d want %h/%b/%h/%0d",
                 i, bus.PC, bus.AddrError, bus.BadVAddr, bus.RedirectCount,
                 m_pc, m_trap, m_bad, m_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    set_idle();
    bus.ClearError = 1;
    tick();
    bus.ClearError = 0;
    bus.BranchTaken = 1; bus.BranchPCPlus4 = 32'h0040_1000; bus.BranchOffset = 32'h0;
    for (int i = 0; i < 65540; i++) tick();
    n_checks++;
    if (bus.RedirectCount !== 16'hFFFF || m_cnt != 65535) begin
      n_fail++;
      $display("FAIL saturate: got %h want ffff (model %0d)", bus.RedirectCount, m_cnt);
    end
    n_checks++;
    if (bus.PC !== 32'h0040_1000) begin
      n_fail++; $display("FAIL saturate_pc: got %h want 00401000", bus.PC);
    end
  endtask

  task automatic test_async_reset();
    // Redirect is presented, then reset rises mid-cycle, well before the next edge.
    bus.JumpRegister = 1; bus.JRTarget = 32'h0000_1234;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (bus.PC !== ResetPc || bus.RedirectCount !== 16'h0 || bus.AddrError !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got pc=%h cnt=%0d err=%b want 00400000/0/0",
               bus.PC, bus.RedirectCount, bus.AddrError);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_idle();
    n_checks++;
    if (bus.PC !== ResetPc) begin
      n_fail++; $display("FAIL reset_release: got %h want 00400000", bus.PC);
    end
    tick();
    n_checks++;
    if (bus.PC !== ResetPc + 32'd4) begin
      n_fail++; $display("FAIL after_release: got %h want 00400004", bus.PC);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_misaligned();
    test_random();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, PC value loaded on reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h8000_0180, PC loaded on address-error trap.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Stall  input  1  hazard hold; PC and all redirect inputs ignored while high.
REQ-006 SHALL have port BranchTaken  input  1  branch decision from ID-stage equality/branch compare.
REQ-007 SHALL have port BranchPCPlus4  input  32  PC+4 of the instruction currently in ID.
REQ-008 SHALL have port BranchOffset  input  32  sign-extended 16-bit immediate (word offset).
REQ-009 SHALL have port Jump  input  1  J/JAL in ID.
REQ-010 SHALL have port JumpAddr26  input  26  J-format target field.
REQ-011 SHALL have port JumpRegister  input  1  JR in ID.
REQ-012 SHALL have port JRTarget  input  32  forwarded rs value for JR.
REQ-013 SHALL have port ClearError  input  1  software acknowledge of address error.
REQ-014 SHALL have port PC  output  32  current fetch address (register).
REQ-015 SHALL have port PCPlus4  output  32  PC + 4, combinational, mod 2^32.
REQ-016 SHALL have port IFIDFlush  output  1  combinational; squash instruction in IF/ID this cycle.
REQ-017 SHALL have port AddrError  output  1  sticky misaligned-redirect flag (register).
REQ-018 SHALL have port BadVAddr  output  32  offending target of last misaligned redirect (register).
REQ-019 SHALL have port RedirectCount  output  16  saturating count of accepted redirects (register).

Function
REQ-020 SHALL compute branch target = BranchPCPlus4 + (BranchOffset << 2), 32-bit wrap-around.
REQ-021 SHALL compute jump target = {BranchPCPlus4[31:28], JumpAddr26, 2'b00}.
REQ-022 SHALL select next PC with priority: Stall (hold) > JumpRegister > Jump > BranchTaken > PCPlus4.
REQ-023 SHALL treat a selected redirect (JR, J, or taken branch with Stall low) as "accepted"; update PC on the next edge (1-cycle latency).
REQ-024 SHALL, when accepted JR target has bits [1:0] != 0, load PC <= EXC_VECTOR, BadVAddr <= JRTarget, AddrError <= 1, state <= TRAP.
REQ-025 SHALL implement states RUN and TRAP; RUN->TRAP on misaligned JR; TRAP->RUN on ClearError high with no misaligned JR that cycle.
REQ-026 SHALL, in TRAP, sequence and redirect normally; a further misaligned JR reloads EXC_VECTOR and updates BadVAddr (nesting allowed).
REQ-027 SHALL give a misaligned JR priority over ClearError in the same cycle (stay/enter TRAP, AddrError stays 1).
REQ-028 SHALL hold AddrError = 1 exactly while state is TRAP.
REQ-029 SHALL increment RedirectCount by 1 per accepted redirect, including trapping ones, saturating at 16'hFFFF.
REQ-030 SHALL never assert IFIDFlush while Stall is high.

Reset
REQ-031 SHALL on reset high, immediately (asynchronously) set PC = RESET_PC, state = RUN, AddrError = 0, BadVAddr = 0, RedirectCount = 0.
REQ-032 SHALL abandon any redirect presented in the cycle reset asserts; first fetch after release is RESET_PC.

Configuration
REQ-033 SHALL recognize macro PC_SEQUENCER_DELAY_SLOT_EN.
REQ-034 SHALL, without the macro, assert IFIDFlush in every cycle a redirect is accepted.
REQ-035 SHALL, with the macro, keep IFIDFlush = 0 for aligned accepted redirects (delay slot executes) and assert it only for trapping JR.

Verification
REQ-036 Reset release, no redirects, 3 cycles -> PC 0x00400000, 0x00400004, 0x00400008, 0x0040000C; IFIDFlush 0.
REQ-037 BranchTaken=1, BranchPCPlus4=0x00400010, BranchOffset=0xFFFFFFFC -> next PC 0x00400000; IFIDFlush 1 (0 with macro); RedirectCount 1.
REQ-038 Jump=1, BranchTaken=1, JumpRegister=1, JRTarget=0x00400100 same cycle -> next PC 0x00400100; Stall=1 with same inputs -> PC held, IFIDFlush 0, count unchanged.
REQ-039 JumpRegister=1, JRTarget=0x00400102 -> PC 0x80000180, AddrError 1, BadVAddr 0x00400102, IFIDFlush 1 in both builds; ClearError=1 next cycle -> AddrError 0.
REQ-040 Force 65540 accepted branches -> RedirectCount saturates at 0xFFFF; assert reset mid-run asynchronously -> PC 0x00400000, count 0 before next edge.
